// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder time-shared LSB-first over WIDTH cycles,
// sequenced by a three-state IDLE/RUN/DONE controller.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_carryOut;

    logic             w_accept;
    logic             w_lastBit;
    logic             w_aBit;
    logic             w_bBit;
    logic             w_sumBit;
    logic             w_carryNext;

    // The single full adder shared by every bit position
    assign w_aBit      = r_a[r_count];
    assign w_bBit      = r_b[r_count];
    assign w_sumBit    = w_aBit ^ w_bBit ^ r_carry;
    assign w_carryNext = (w_aBit & w_bBit) | (w_aBit & r_carry) | (w_bBit & r_carry);

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastBit = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (w_lastBit) w_nextState = DONE;
            DONE:    w_nextState = start ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operands are only captured on acceptance, so input changes mid-run are harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_carryOut <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_count <= '0;
            r_carry <= carry_in;
        end else if (r_state == RUN) begin
            r_sum[r_count] <= w_sumBit;
            r_carry        <= w_carryNext;
            if (w_lastBit) begin
                r_carryOut <= w_carryNext;
                r_count    <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carryOut;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: reset, single additions,
// boundary operands, back-to-back streaming and mid-run reset.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;
    logic             done;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({sum, carry_out, busy, done} !== {8'h00, 3'b000}) begin
            bad++;
            $display("[TB] FAIL reset_async: sum=%h cout=%b busy=%b done=%b, want 00 0 0 0",
                     sum, carry_out, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({sum, carry_out, busy, done} !== {8'h00, 3'b000}) begin
                bad++;
                $display("[TB] FAIL reset_idle[%0d]: sum=%h cout=%b busy=%b done=%b, want 00 0 0 0",
                         i, sum, carry_out, busy, done);
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        a = 8'h35; b = 8'h4A; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'hAA; b = 8'h55; carry_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL basic_busy[%0d]: busy=%b done=%b, want 1 0", i, busy, done);
            end
            if (i == 3) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h7F || carry_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_done: done=%b busy=%b sum=%h cout=%b, want 1 0 7f 0",
                     done, busy, sum, carry_out);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h7F || carry_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_hold: done=%b busy=%b sum=%h cout=%b, want 0 0 7f 0",
                     done, busy, sum, carry_out);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] tA   [4] = '{8'hFF, 8'hFF, 8'h00, 8'h80};
        logic [7:0] tB   [4] = '{8'h00, 8'hFF, 8'h00, 8'h7F};
        logic       tC   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] tSum [4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
        logic       tCo  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 4; t++) begin
            int cycles;
            @(negedge clk);
            a = tA[t]; b = tB[t]; carry_in = tC[t]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cycles = 1;
            while (done !== 1'b1 && cycles < 30) begin
                @(negedge clk);
                cycles++;
            end
            total++;
            if (done !== 1'b1 || cycles != 9 || sum !== tSum[t] || carry_out !== tCo[t]) begin
                bad++;
                $display("[TB] FAIL boundary[%0d]: done=%b lat=%0d sum=%h cout=%b, want 1 9 %h %b",
                         t, done, cycles, sum, carry_out, tSum[t], tCo[t]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] tA   [3] = '{8'h01, 8'h80, 8'h3C};
        logic [7:0] tB   [3] = '{8'h02, 8'h80, 8'hC3};
        logic       tC   [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] tSum [3] = '{8'h03, 8'h01, 8'hFF};
        logic       tCo  [3] = '{1'b0, 1'b1, 1'b0};
        int idx;
        int lastDone;
        @(negedge clk);
        a = tA[0]; b = tB[0]; carry_in = tC[0]; start = 1'b1;
        idx = 0;
        lastDone = -1;
        for (int cyc = 0; cyc < 60 && idx < 3; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                total++;
                if (sum !== tSum[idx] || carry_out !== tCo[idx]) begin
                    bad++;
                    $display("[TB] FAIL b2b_result[%0d]: sum=%h cout=%b, want %h %b",
                             idx, sum, carry_out, tSum[idx], tCo[idx]);
                end
                if (lastDone >= 0) begin
                    total++;
                    if (cyc - lastDone != 9) begin
                        bad++;
                        $display("[TB] FAIL b2b_spacing[%0d]: gap=%0d, want 9", idx, cyc - lastDone);
                    end
                end
                lastDone = cyc;
                idx++;
                if (idx < 3) begin
                    a = tA[idx]; b = tB[idx]; carry_in = tC[idx];
                end else begin
                    start = 1'b0;
                end
            end else if (busy === 1'b1) begin
                a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
            end
        end
        start = 1'b0;
        total++;
        if (idx != 3) begin
            bad++;
            $display("[TB] FAIL b2b_count: results=%0d, want 3", idx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int doneSeen;
        @(negedge clk);
        a = 8'h05; b = 8'h02; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sum, carry_out, busy, done} !== {8'h00, 3'b000}) begin
            bad++;
            $display("[TB] FAIL midrun_clear: sum=%h cout=%b busy=%b done=%b, want 00 0 0 0",
                     sum, carry_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) doneSeen++;
        end
        total++;
        if (doneSeen != 0 || sum !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midrun_nodone: activeCycles=%0d sum=%h, want 0 00", doneSeen, sum);
        end
        a = 8'h12; b = 8'h34; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (done !== 1'b1 || sum !== 8'h47 || carry_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrun_next: done=%b sum=%h cout=%b, want 1 47 0",
                     done, sum, carry_out);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        start = 1'b0;
        a = '0;
        b = '0;
        carry_in = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be legal for 2 to 32.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled on a rising clk edge.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: carry_in  input  1  initial carry; captured when start is accepted.
REQ-008 Port: sum  output  WIDTH  registered result; holds its value between operations.
REQ-009 Port: carry_out  output  1  registered final carry; holds its value between operations.
REQ-010 Port: busy  output  1  high while an addition is in progress.
REQ-011 Port: done  output  1  one-cycle pulse marking a valid new sum/carry_out.

Function
REQ-012 The block SHALL contain exactly one 1-bit full-adder datapath, time-shared LSB-first across all WIDTH bit positions.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a clock edge SHALL be accepted; the edge SHALL capture a, b and carry_in, clear the bit counter to 0, and enter RUN.
REQ-015 In IDLE with start=0, the FSM SHALL remain in IDLE; in DONE with start=0, it SHALL go to IDLE.
REQ-016 In RUN, each edge SHALL add operand bit[count] and captured-B bit[count] with the carry register: sum bit = XOR of the three inputs, new carry = majority of the three inputs.
REQ-017 In RUN, each edge SHALL write the sum bit into sum position [count], update the carry register, and increment count.
REQ-018 On the edge that processes bit WIDTH-1, the FSM SHALL load carry_out from the new carry and enter DONE.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high during exactly the cycle following edge k+WIDTH.
REQ-020 busy SHALL be 1 exactly while the state is RUN.
REQ-021 done SHALL be 1 exactly while the state is DONE.
REQ-022 start during RUN SHALL be ignored; the operation in progress SHALL be neither restarted nor corrupted.
REQ-023 Changes on a, b or carry_in after acceptance SHALL NOT affect the operation in progress.
REQ-024 Back-to-back operation: start=1 in the DONE cycle SHALL be accepted, giving one new result every WIDTH+1 cycles.
REQ-025 sum bits not yet rewritten during RUN may hold intermediate values; sum and carry_out SHALL be architecturally valid only while done=1 and afterwards until the next acceptance.
REQ-026 The result SHALL equal (a + b + carry_in) mod 2^WIDTH, and carry_out SHALL equal bit WIDTH of that sum, including at the all-ones boundary.

Reset
REQ-027 rst_n=0 SHALL, without a clock edge, force state=IDLE, count=0, carry register=0, sum=0, carry_out=0, busy=0 and done=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the partial result SHALL be discarded.
REQ-029 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge at which rst_n=1.

Verification (WIDTH=8)
REQ-030 Reset then idle: sum=0x00, carry_out=0, busy=0 and done=0 for 20 cycles with start=0.
REQ-031 a=0x35, b=0x4A, carry_in=0, start pulsed at edge k: busy high for 8 cycles, then done high one cycle after edge k+8, sum=0x7F, carry_out=0.
REQ-032 a=0xFF, b=0x00, carry_in=1: sum=0x00, carry_out=1.
REQ-033 a=0xFF, b=0xFF, carry_in=1: sum=0xFF, carry_out=1.
REQ-034 Start held high continuously with new operands each DONE cycle: results spaced 9 cycles apart; a start pulse and operand changes during RUN have no effect.
REQ-035 rst_n pulsed low at bit 4 of an operation: outputs clear immediately, no done pulse follows, and the next addition gives the correct result.
